forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/hazard_pkg.sv | 13 +
 rtl/forward_hazard_unit_if.sv | 37 +++
 rtl/fwd_slot_cmp.sv | 25 ++
 rtl/forward_hazard_unit.sv | 90 +++++++++
 tb/tb_forward_hazard_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand mux selects and MDU FSM states.
package hazard_pkg;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mduState_t;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle; master is the pipeline datapath, slave is the hazard unit.
interface forward_hazard_unit_if #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2
);
   logic [NUM_SRC*REG_AW-1:0] id_src_addr;
   logic [NUM_SRC-1:0]        id_src_used;
   logic                      id_mdu_op;
   logic [REG_AW-1:0]         id_mdu_rd;
   logic [NUM_SRC*REG_AW-1:0] ex_src_addr;
   logic                      ex_regwrite;
   logic                      ex_memread;
   logic [REG_AW-1:0]         ex_rd;
   logic                      mem_regwrite;
   logic [REG_AW-1:0]         mem_rd;
   logic                      wb_regwrite;
   logic [REG_AW-1:0]         wb_rd;
   logic [2*NUM_SRC-1:0]      fwd_sel;
   logic                      stall;
   logic                      flush_ex;
   logic                      mdu_busy;
   logic [15:0]               stall_cnt;

   modport master (
      output id_src_addr, id_src_used, id_mdu_op, id_mdu_rd,
      output ex_src_addr, ex_regwrite, ex_memread, ex_rd,
      output mem_regwrite, mem_rd, wb_regwrite, wb_rd,
      input  fwd_sel, stall, flush_ex, mdu_busy, stall_cnt
   );

   modport slave (
      input  id_src_addr, id_src_used, id_mdu_op, id_mdu_rd,
      input  ex_src_addr, ex_regwrite, ex_memread, ex_rd,
      input  mem_regwrite, mem_rd, wb_regwrite, wb_rd,
      output fwd_sel, stall, flush_ex, mdu_busy, stall_cnt
   );
endinterface

// File: rtl/fwd_slot_cmp.sv
// One EX operand's forward select; purely combinational, EX/MEM wins over MEM/WB, r0 never forwards.
module fwd_slot_cmp
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] exAddr,
   input  logic              memRegwrite,
   input  logic [REG_AW-1:0] memRd,
   input  logic              wbRegwrite,
   input  logic [REG_AW-1:0] wbRd,
   output logic [1:0]        fwdSel
);
   logic memHit;
   logic wbHit;

   assign memHit = memRegwrite && (memRd != '0) && (memRd == exAddr);
   assign wbHit  = wbRegwrite  && (wbRd  != '0) && (wbRd  == exAddr);

   always_comb begin
      fwdSel = FWD_NONE;
      if (memHit)     fwdSel = FWD_MEM;
      else if (wbHit) fwdSel = FWD_WB;
   end
endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding plus load-use / multi-cycle MDU stall generation; fwd_sel and stall are combinational.
// Issue into the MDU is refused while any stall is raised; stall_cnt saturates at all-ones.
module forward_hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int MDU_LAT = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   forward_hazard_unit_if.slave hz
);
   localparam int CNT_W = $clog2(MDU_LAT);

   mduState_t            state;
   logic [CNT_W-1:0]     cnt;
   logic [REG_AW-1:0]    mduDst;
   logic [2*NUM_SRC-1:0] fwdSel;
   logic                 loadHit;
   logic                 dstHit;
   logic                 loadUse;
   logic                 mduHazard;
   logic                 stallInt;
   logic [15:0]          stallCnt;
   logic                 unusedExRegwrite;

   // A load already implies a register write, so only memread matters here.
   assign unusedExRegwrite = hz.ex_regwrite;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
      fwd_slot_cmp #(.REG_AW(REG_AW)) u_cmp (
         .exAddr      (hz.ex_src_addr[k*REG_AW +: REG_AW]),
         .memRegwrite (hz.mem_regwrite),
         .memRd       (hz.mem_rd),
         .wbRegwrite  (hz.wb_regwrite),
         .wbRd        (hz.wb_rd),
         .fwdSel      (fwdSel[2*k +: 2])
      );
   end

   always_comb begin
      loadHit = 1'b0;
      dstHit  = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (hz.id_src_used[k]) begin
            if (hz.id_src_addr[k*REG_AW +: REG_AW] == hz.ex_rd) loadHit = 1'b1;
            if (hz.id_src_addr[k*REG_AW +: REG_AW] == mduDst)   dstHit  = 1'b1;
         end
      end
   end

   assign loadUse   = hz.ex_memread && (hz.ex_rd != '0) && loadHit;
   assign mduHazard = (state == BUSY) && (hz.id_mdu_op || ((mduDst != '0) && dstHit));
   assign stallInt  = loadUse || mduHazard;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         mduDst <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hz.id_mdu_op && !stallInt) begin
                  state  <= BUSY;
                  mduDst <= hz.id_mdu_rd;
                  cnt    <= CNT_W'(MDU_LAT - 1);
               end
            end
            BUSY: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              stallCnt <= '0;
      else if (stallInt && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
   end

   assign hz.fwd_sel   = fwdSel;
   assign hz.stall     = stallInt;
   assign hz.flush_ex  = stallInt;
   assign hz.mdu_busy  = (state == BUSY);
   assign hz.stall_cnt = stallCnt;
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Randomized and directed stimulus against a cycle-level reference model of forwarding and stalls.
module tb_forward_hazard_unit;
   localparam int REG_AW  = 5;
   localparam int NUM_SRC = 2;
   localparam int MDU_LAT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   forward_hazard_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) hz ();

   forward_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MDU_LAT(MDU_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   int total = 0;
   int bad   = 0;

   // next-cycle stimulus
   logic [NUM_SRC*REG_AW-1:0] nIdSrc, nExSrc;
   logic [NUM_SRC-1:0]        nIdUsed;
   logic                      nMduOp, nExRw, nExMr, nMemRw, nWbRw;
   logic [REG_AW-1:0]         nMduRd, nExRd, nMemRd, nWbRd;

   // reference model: remaining busy cycles, pending destination, stall count
   int mLeft = 0;
   int mDst  = 0;
   int mCnt  = 0;

   logic obsBusy, obsStall;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clearIn();
      nIdSrc = '0; nExSrc = '0; nIdUsed = '0; nMduOp = 1'b0; nExRw = 1'b0; nExMr = 1'b0;
      nMemRw = 1'b0; nWbRw = 1'b0; nMduRd = '0; nExRd = '0; nMemRd = '0; nWbRd = '0;
   endtask

   task automatic step(input logic rst, input bit doCheck);
      logic [2*NUM_SRC-1:0] expSel;
      bit loadUse, dstUse, expStall;
      int a, idA;
      @(negedge clk);
      hz.id_src_addr = nIdSrc;  hz.id_src_used = nIdUsed; hz.id_mdu_op = nMduOp;
      hz.id_mdu_rd = nMduRd;    hz.ex_src_addr = nExSrc;  hz.ex_regwrite = nExRw;
      hz.ex_memread = nExMr;    hz.ex_rd = nExRd;         hz.mem_regwrite = nMemRw;
      hz.mem_rd = nMemRd;       hz.wb_regwrite = nWbRw;   hz.wb_rd = nWbRd;
      rst_n = rst;
      if (!rst) begin
         mLeft = 0; mDst = 0; mCnt = 0;
      end
      #1;
      expSel = '0; loadUse = 0; dstUse = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         a   = int'(nExSrc[k*REG_AW +: REG_AW]);
         idA = int'(nIdSrc[k*REG_AW +: REG_AW]);
         if (nMemRw && nMemRd != 0 && int'(nMemRd) == a)  expSel[2*k +: 2] = 2'b10;
         else if (nWbRw && nWbRd != 0 && int'(nWbRd) == a) expSel[2*k +: 2] = 2'b01;
         if (nIdUsed[k] && nExMr && nExRd != 0 && idA == int'(nExRd)) loadUse = 1;
         if (nIdUsed[k] && mDst != 0 && idA == mDst) dstUse = 1;
      end
      expStall = loadUse || (mLeft > 0 && (nMduOp || dstUse));
      obsBusy  = hz.mdu_busy;
      obsStall = hz.stall;
      if (doCheck) begin
         checkVal("fwd_sel", 32'(hz.fwd_sel), 32'(expSel));
         checkVal("stall", 32'(hz.stall), 32'(expStall));
         checkVal("flush_ex", 32'(hz.flush_ex), 32'(expStall));
         checkVal("mdu_busy", 32'(hz.mdu_busy), 32'(mLeft > 0));
         checkVal("stall_cnt", 32'(hz.stall_cnt), 32'(mCnt));
      end
      @(posedge clk);
      if (rst) begin
         if (expStall && mCnt < 65535) mCnt++;
         if (mLeft > 0) mLeft--;
         else if (nMduOp && !expStall) begin
            mLeft = MDU_LAT;
            mDst  = int'(nMduRd);
         end
      end
   endtask

   int busyCycles, stallCycles;

   initial begin
      clearIn();
      // reset with all inputs zero: every output zero
      step(1'b0, 1'b1);
      checkVal("rst_busy", 32'(hz.mdu_busy), 32'd0);
      checkVal("rst_fwd", 32'(hz.fwd_sel), 32'd0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);

      // EX/MEM and MEM/WB forwarding to distinct slots
      clearIn();
      nMemRw = 1'b1; nMemRd = 5'd5; nWbRw = 1'b1; nWbRd = 5'd3;
      nExSrc = {5'd3, 5'd5};
      step(1'b1, 1'b1);
      checkVal("fwd_pair", 32'(hz.fwd_sel), 32'h6);
      // same register in both stages: EX/MEM wins; r0 never forwards
      nWbRd = 5'd5; nExSrc = {5'd0, 5'd5};
      nMemRd = 5'd5;
      step(1'b1, 1'b1);

      // load-use for exactly the cycle it is present
      clearIn();
      nExMr = 1'b1; nExRw = 1'b1; nExRd = 5'd7; nIdSrc = {5'd7, 5'd2}; nIdUsed = 2'b10;
      step(1'b1, 1'b1);
      checkVal("lu_stall", 32'(obsStall), 32'd1);
      nIdUsed = 2'b01;
      step(1'b1, 1'b1);
      checkVal("lu_unused", 32'(obsStall), 32'd0);

      // MDU issue, then dependent read held for the whole latency
      clearIn();
      nMduOp = 1'b1; nMduRd = 5'd9;
      step(1'b1, 1'b1);
      nMduOp = 1'b0; nIdSrc = {5'd1, 5'd9}; nIdUsed = 2'b11;
      busyCycles = 0; stallCycles = 0;
      for (int i = 0; i < MDU_LAT + 2; i++) begin
         step(1'b1, 1'b1);
         busyCycles  += int'(obsBusy);
         stallCycles += int'(obsStall);
      end
      checkVal("mdu_busy_len", 32'(busyCycles), 32'(MDU_LAT));
      checkVal("mdu_stall_len", 32'(stallCycles), 32'(MDU_LAT));

      // back-to-back MDU ops: second waits for IDLE, then updates destination
      clearIn();
      nMduOp = 1'b1; nMduRd = 5'd10;
      step(1'b1, 1'b1);
      nMduRd = 5'd12;
      for (int i = 0; i < MDU_LAT + 1; i++) step(1'b1, 1'b1);
      nMduOp = 1'b0; nIdSrc = {5'd0, 5'd12}; nIdUsed = 2'b01;
      step(1'b1, 1'b1);
      checkVal("mdu_new_dst", 32'(obsStall), 32'd1);
      clearIn();
      for (int i = 0; i < MDU_LAT + 1; i++) step(1'b1, 1'b1);
      nMduOp = 1'b1; nMduRd = 5'd0;
      step(1'b1, 1'b1);
      nMduOp = 1'b0; nIdSrc = '0; nIdUsed = 2'b11;
      step(1'b1, 1'b1);
      checkVal("mdu_r0", 32'(obsStall), 32'd0);
      clearIn();
      for (int i = 0; i < MDU_LAT; i++) step(1'b1, 1'b1);

      // reset in the middle of a busy period
      nMduOp = 1'b1; nMduRd = 5'd9;
      step(1'b1, 1'b1);
      nMduOp = 1'b0; nIdSrc = {5'd9, 5'd9}; nIdUsed = 2'b11;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      checkVal("rst_mid_busy", 32'(obsBusy), 32'd0);
      checkVal("rst_mid_stall", 32'(obsStall), 32'd0);
      checkVal("rst_mid_cnt", 32'(hz.stall_cnt), 32'd0);
      step(1'b1, 1'b1);

      // random traffic over a small register window to provoke hits
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            nIdSrc[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
            nExSrc[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
         end
         nIdUsed = NUM_SRC'($urandom);
         nMduOp  = ($urandom_range(0, 3) == 0);
         nMduRd  = REG_AW'($urandom_range(0, 7));
         nExRw   = 1'($urandom);
         nExMr   = ($urandom_range(0, 2) == 0);
         nExRd   = REG_AW'($urandom_range(0, 7));
         nMemRw  = 1'($urandom);
         nMemRd  = REG_AW'($urandom_range(0, 7));
         nWbRw   = 1'($urandom);
         nWbRd   = REG_AW'($urandom_range(0, 7));
         step(($urandom_range(0, 199) != 0), 1'b1);
      end

      // long held load-use: counter saturates
      clearIn();
      step(1'b0, 1'b1);
      nExMr = 1'b1; nExRd = 5'd3; nIdSrc = {5'd0, 5'd3}; nIdUsed = 2'b01;
      for (int i = 0; i < 70000; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      checkVal("stall_cnt_sat", 32'(hz.stall_cnt), 32'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
